// File: rtl/step_seq_pkg.sv
// rtl/step_seq_pkg.sv - shared state encoding and default sizes for the step sequencer
package step_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_PLAY = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DEF_NUM_STEPS = 16;
    localparam int DEF_TONE_W    = 12;
    localparam int DEF_LOOP_W    = 8;

endpackage

// File: rtl/step_sequencer_ctrl_if.sv
// rtl/step_sequencer_ctrl_if.sv - control, pattern-write and playback signals of the step sequencer
interface step_sequencer_ctrl_if
    import step_seq_pkg::*;
#(
    parameter int NUM_STEPS = DEF_NUM_STEPS,
    parameter int TONE_W    = DEF_TONE_W,
    parameter int LOOP_W    = DEF_LOOP_W
) ();
    localparam int AW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;

    logic              start;
    logic              stop;
    logic              step_tick;
    logic [LOOP_W-1:0] loops;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [TONE_W-1:0] wr_data;
    logic [TONE_W-1:0] select;
    logic              note_restart;
    logic              play;
    logic [AW-1:0]     step_idx;
    logic [LOOP_W-1:0] loop_idx;
    logic              done;

    modport master (
        output start, stop, step_tick, loops, wr_en, wr_addr, wr_data,
        input  select, note_restart, play, step_idx, loop_idx, done
    );

    modport slave (
        input  start, stop, step_tick, loops, wr_en, wr_addr, wr_data,
        output select, note_restart, play, step_idx, loop_idx, done
    );
endinterface

// File: rtl/step_pattern_ram.sv
// rtl/step_pattern_ram.sv - pattern store, one write port and one registered read port (read-before-write)
module step_pattern_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 12,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    // Both ports sample mem_q before the edge, so a same-address read sees the old word.
    always_ff @(posedge clk) begin
        if (wr_en && (int'(wr_addr) < DEPTH)) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en && (int'(rd_addr) < DEPTH)) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;
endmodule

// File: rtl/step_sequencer_ctrl.sv
// rtl/step_sequencer_ctrl.sv - pattern scheduler: steps stored tone masks into the generators on BPM ticks
module step_sequencer_ctrl
    import step_seq_pkg::*;
#(
    parameter int NUM_STEPS = DEF_NUM_STEPS,
    parameter int TONE_W    = DEF_TONE_W,
    parameter int LOOP_W    = DEF_LOOP_W
) (
    input logic                 CLOCK_50,
    input logic                 reset,
    step_sequencer_ctrl_if.slave bus
);
    localparam int                AW        = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [AW-1:0]     LAST_STEP = AW'(NUM_STEPS - 1);
    localparam logic [LOOP_W-1:0] LOOP_MAX  = '1;

    state_t            state_q, state_d;
    logic [AW-1:0]     step_idx_q, step_idx_d;
    logic [LOOP_W-1:0] loop_idx_q, loop_idx_d;
    logic [LOOP_W-1:0] loops_q, loops_d;
    logic              play_q, play_d;
    logic              sel_valid_q, sel_valid_d;
    logic              note_restart_q, note_restart_d;
    logic              done_q, done_d;
    logic              rd_en;
    logic [TONE_W-1:0] rd_data;
    logic [LOOP_W:0]   next_loop;

    step_pattern_ram #(
        .DEPTH (NUM_STEPS),
        .WIDTH (TONE_W),
        .AW    (AW)
    ) u_ram (
        .clk     (CLOCK_50),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_en   (rd_en),
        .rd_addr (step_idx_q),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d        = state_q;
        step_idx_d     = step_idx_q;
        loop_idx_d     = loop_idx_q;
        loops_d        = loops_q;
        play_d         = play_q;
        sel_valid_d    = sel_valid_q;
        note_restart_d = 1'b0;
        done_d         = 1'b0;
        rd_en          = 1'b0;
        next_loop      = {1'b0, loop_idx_q} + (LOOP_W+1)'(1);

        if (bus.stop && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            play_d      = 1'b0;
            sel_valid_d = 1'b0;
        end else if (bus.start) begin
            state_d    = ST_LOAD;
            step_idx_d = '0;
            loop_idx_d = '0;
            loops_d    = bus.loops;
            play_d     = 1'b1;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    rd_en          = 1'b1;
                    sel_valid_d    = 1'b1;
                    note_restart_d = 1'b1;
                    state_d        = ST_PLAY;
                end
                ST_PLAY: begin
                    if (bus.step_tick) begin
                        if (step_idx_q != LAST_STEP) begin
                            step_idx_d = step_idx_q + AW'(1);
                            state_d    = ST_LOAD;
                        end else if ((loops_q != '0) && (next_loop == {1'b0, loops_q})) begin
                            state_d = ST_DONE;
                        end else begin
                            // Infinite runs pin the loop count at all-ones instead of wrapping.
                            loop_idx_d = next_loop[LOOP_W] ? LOOP_MAX : next_loop[LOOP_W-1:0];
                            step_idx_d = '0;
                            state_d    = ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    done_d      = 1'b1;
                    play_d      = 1'b0;
                    sel_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            step_idx_q     <= '0;
            loop_idx_q     <= '0;
            loops_q        <= '0;
            play_q         <= 1'b0;
            sel_valid_q    <= 1'b0;
            note_restart_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            step_idx_q     <= step_idx_d;
            loop_idx_q     <= loop_idx_d;
            loops_q        <= loops_d;
            play_q         <= play_d;
            sel_valid_q    <= sel_valid_d;
            note_restart_q <= note_restart_d;
            done_q         <= done_d;
        end
    end

    // The RAM read register is not reset, so select is gated until a step has been loaded.
    assign bus.select       = sel_valid_q ? rd_data : '0;
    assign bus.note_restart = note_restart_q;
    assign bus.play         = play_q;
    assign bus.step_idx     = step_idx_q;
    assign bus.loop_idx     = loop_idx_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_step_sequencer_ctrl.sv
// tb/tb_step_sequencer_ctrl.sv - randomized scoreboard bench for step_sequencer_ctrl
module tb_step_sequencer_ctrl;
    localparam int NS = 16;
    localparam int TW = 12;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    step_sequencer_ctrl_if #(.NUM_STEPS(NS), .TONE_W(TW), .LOOP_W(LW)) bus ();

    step_sequencer_ctrl #(.NUM_STEPS(NS), .TONE_W(TW), .LOOP_W(LW)) dut (
        .CLOCK_50 (clk),
        .reset    (rst),
        .bus      (bus)
    );

    typedef struct {
        bit          is_done;
        logic [TW-1:0] sel;
        int          step;
        int          loopi;
        int          due;
    } exp_t;

    exp_t          expq[$];
    logic [TW-1:0] mem_m [NS];
    bit            m_play;
    int            m_step, m_loop, m_loops;
    int            checks = 0;
    int            errors = 0;
    int            done_seen = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_note(int step);
        exp_t e;
        e.is_done = 1'b0; e.sel = mem_m[step]; e.step = step; e.loopi = m_loop; e.due = cyc + 2;
        expq.push_back(e);
    endtask

    task automatic push_done();
        exp_t e;
        e.is_done = 1'b1; e.sel = '0; e.step = 0; e.loopi = 0; e.due = cyc + 2;
        expq.push_back(e);
    endtask

    // Monitor: every note_restart or done pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst && (bus.note_restart || bus.done)) begin
            if (bus.done) done_seen++;
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got note=%0b done=%0b expected none (cycle %0d)",
                         bus.note_restart, bus.done, cyc);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("event_latency", cyc, e.due);
                if (e.is_done) begin
                    chk("done_kind", {bus.done, bus.note_restart}, 2'b10);
                    chk("done_play", bus.play, 0);
                    chk("done_select", bus.select, 0);
                end else begin
                    chk("note_kind", {bus.done, bus.note_restart}, 2'b01);
                    chk("note_select", bus.select, e.sel);
                    chk("note_step", bus.step_idx, e.step);
                    chk("note_loop", bus.loop_idx, e.loopi);
                    chk("note_play", bus.play, 1);
                end
            end
        end
    end

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(int a, logic [TW-1:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = 4'(a); bus.wr_data = d;
        mem_m[a] = d;
        edge1();
        bus.wr_en = 1'b0;
    endtask

    task automatic start_run(int lp, bit with_tick);
        bus.loops = 8'(lp); bus.start = 1'b1; bus.step_tick = with_tick;
        m_play = 1'b1; m_step = 0; m_loop = 0; m_loops = lp;
        push_note(0);
        edge1();
        bus.start = 1'b0; bus.step_tick = 1'b0;
        chk("start_play", bus.play, 1);
        chk("start_step", bus.step_idx, 0);
    endtask

    task automatic tick();
        if (m_play) begin
            if (m_step < NS - 1) begin
                m_step++;
                push_note(m_step);
            end else if (m_loops != 0 && m_loop + 1 == m_loops) begin
                m_play = 1'b0;
                push_done();
            end else begin
                m_loop = (m_loop + 1 > 255) ? 255 : m_loop + 1;
                m_step = 0;
                push_note(0);
            end
        end
        bus.step_tick = 1'b1;
        edge1();
        bus.step_tick = 1'b0;
    endtask

    task automatic run_ticks(int n, int gap_lo, int gap_hi);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gap_hi, gap_lo) - 1) edge1();
            tick();
        end
    endtask

    task automatic do_stop();
        bus.stop = 1'b1;
        m_play = 1'b0;
        edge1();
        bus.stop = 1'b0;
        chk("stop_play", bus.play, 0);
        chk("stop_select", bus.select, 0);
        chk("stop_done", bus.done, 0);
    endtask

    initial begin
        int d0;
        bus.start = 0; bus.stop = 0; bus.step_tick = 0; bus.loops = 0;
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
        m_play = 0; m_step = 0; m_loop = 0; m_loops = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_select", bus.select, 0);
        chk("rst_play", bus.play, 0);
        chk("rst_step", bus.step_idx, 0);
        chk("rst_loop", bus.loop_idx, 0);
        chk("rst_note", bus.note_restart, 0);
        chk("rst_done", bus.done, 0);
        rst = 1'b0;
        edge1();

        for (int a = 0; a < NS; a++) do_write(a, 12'($urandom));
        do_write(0, 12'h001); do_write(1, 12'h002); do_write(2, 12'h004); do_write(3, 12'h008);

        // single loop, widely spaced ticks
        start_run(1, 0);
        run_ticks(16, 100, 100);
        repeat (3) edge1();
        chk("t1_done_count", done_seen, 1);
        chk("t1_play", bus.play, 0);
        chk("t1_select", bus.select, 0);
        chk("t1_queue", expq.size(), 0);

        // three loops, exactly one done
        d0 = done_seen;
        start_run(3, 0);
        run_ticks(48, 2, 5);
        repeat (3) edge1();
        chk("t2_done_count", done_seen - d0, 1);

        // infinite mode
        d0 = done_seen;
        start_run(0, 0);
        run_ticks(100, 2, 4);
        repeat (3) edge1();
        chk("t3_loop_idx", bus.loop_idx, 6);
        chk("t3_play", bus.play, 1);
        chk("t3_no_done", done_seen - d0, 0);
        do_stop();

        // stop at step 5, later ticks ignored
        start_run(2, 0);
        run_ticks(5, 2, 4);
        repeat (3) edge1();
        chk("t4_step", bus.step_idx, 5);
        do_stop();
        run_ticks(3, 2, 4);
        repeat (3) edge1();
        chk("t4_idle_play", bus.play, 0);

        // start with same-cycle tick, then write mem[0] on the LOAD edge
        start_run(2, 0);
        run_ticks(7, 2, 4);
        repeat (3) edge1();
        start_run(2, 1);
        do_write(0, 12'hA5C);
        run_ticks(32, 2, 3);
        repeat (3) edge1();
        chk("t5_queue", expq.size(), 0);

        // reset mid-play at step 9, memory retained
        start_run(1, 0);
        run_ticks(9, 2, 3);
        repeat (3) edge1();
        chk("t6_step_pre", bus.step_idx, 9);
        rst = 1'b1;
        m_play = 1'b0;
        edge1();
        chk("t6_select", bus.select, 0);
        chk("t6_play", bus.play, 0);
        chk("t6_step", bus.step_idx, 0);
        chk("t6_loop", bus.loop_idx, 0);
        chk("t6_note", bus.note_restart, 0);
        chk("t6_done", bus.done, 0);
        rst = 1'b0;
        edge1();
        start_run(1, 0);
        run_ticks(16, 2, 3);
        repeat (3) edge1();

        // randomized runs with idle writes and random early stops
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(4, 1)) do_write($urandom_range(NS - 1, 0), 12'($urandom));
            start_run($urandom_range(2, 1), 0);
            run_ticks($urandom_range(40, 10), 2, 6);
            repeat (3) edge1();
            if ($urandom_range(1, 0) == 1) do_stop();
            repeat (3) edge1();
        end

        // infinite mode loop-count saturation
        start_run(0, 0);
        run_ticks(257 * NS, 2, 2);
        repeat (3) edge1();
        chk("sat_loop_idx", bus.loop_idx, 255);
        do_stop();
        repeat (3) edge1();

        chk("final_queue", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
